// File: rtl/mips_bus_arbiter.sv
// Two-master (instruction/data) arbiter onto one shared memory-slave bus.
// It allows one outstanding transfer. Read data returns to the owner one cycle after the RESP cycle.
module mips_bus_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_readdatavalid,
  // data master
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readdatavalid,
  // shared slave bus
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } bus_req_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t   state, state_nxt;
  logic     last_grant, last_grant_nxt;
  logic     owner, owner_nxt;
  logic     i_req, d_req, pick;
  bus_req_t bus;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Contested pick: alternate away from the previous winner, or favour D.
  always_comb begin
    pick = d_req ? GNT_D : GNT_I;
    if (i_req && d_req)
      pick = RR_ENABLE ? ~last_grant : GNT_D;
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    bus            = '0;
    i_waitrequest  = 1'b1;
    d_waitrequest  = 1'b1;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt      = (pick == GNT_D) ? GRANT_D : GRANT_I;
          last_grant_nxt = pick;
        end
      end
      GRANT_I: begin
        bus.address    = i_address;
        bus.read       = i_read;
        bus.byteenable = 4'b1111;
        i_waitrequest  = waitrequest;
        if (!i_req)
          state_nxt = IDLE;
        else if (!waitrequest) begin
          state_nxt = RESP;
          owner_nxt = GNT_I;
        end
      end
      GRANT_D: begin
        // Write wins when both strobes are set.
        bus.address    = d_address;
        bus.write      = d_write;
        bus.read       = d_read & ~d_write;
        bus.writedata  = d_writedata;
        bus.byteenable = d_byteenable;
        d_waitrequest  = waitrequest;
        if (!d_req)
          state_nxt = IDLE;
        else if (!waitrequest) begin
          state_nxt = d_write ? IDLE : RESP;
          owner_nxt = GNT_D;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign address    = bus.address;
  assign read       = bus.read;
  assign write      = bus.write;
  assign writedata  = bus.writedata;
  assign byteenable = bus.byteenable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      owner      <= GNT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_readdata      <= '0;
      d_readdata      <= '0;
      i_readdatavalid <= 1'b0;
      d_readdatavalid <= 1'b0;
    end else begin
      i_readdatavalid <= (state == RESP) && (owner == GNT_I);
      d_readdatavalid <= (state == RESP) && (owner == GNT_D);
      if (state == RESP && owner == GNT_I) i_readdata <= readdata;
      if (state == RESP && owner == GNT_D) d_readdata <= readdata;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed latency/stall/abort/reset/contention cases,
// then random two-master traffic against a word-memory slave model.
module tb_mips_bus_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] i_address = '0, d_address = '0, d_writedata = '0, readdata = '0;
  logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, waitrequest = 1'b0;
  logic [3:0]  d_byteenable = '0;
  logic        i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  logic [31:0] i_readdata, d_readdata, address, writedata;
  logic        read, write;
  logic [3:0]  byteenable;
  logic        fp_i_waitrequest, fp_i_readdatavalid, fp_d_waitrequest, fp_d_readdatavalid;
  logic [31:0] fp_i_readdata, fp_d_readdata, fp_address, fp_writedata;
  logic        fp_read, fp_write;
  logic [3:0]  fp_byteenable;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.RR_ENABLE(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest),
    .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  // Fixed-priority variant sharing the same master/slave inputs.
  mips_bus_arbiter #(.RR_ENABLE(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(fp_i_waitrequest),
    .i_readdata(fp_i_readdata), .i_readdatavalid(fp_i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(fp_d_waitrequest),
    .d_readdata(fp_d_readdata), .d_readdatavalid(fp_d_readdatavalid),
    .address(fp_address), .read(fp_read), .write(fp_write), .writedata(fp_writedata),
    .byteenable(fp_byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] mem [16];
  logic [31:0] rd_val, i_a, i_exp, d_exp;
  logic        rd_pend, exp_d, i_acc, d_acc, s_acc, d_isrd;
  int          n_acc, n_gnt, n_fp, i_busy, d_busy, i_to, d_to, d_kind;

  initial begin
    // reset values
    @(negedge clk); #1;
    chk("rst_read", read, 0);        chk("rst_write", write, 0);
    chk("rst_addr", address, 0);     chk("rst_wdata", writedata, 0);
    chk("rst_be", byteenable, 0);    chk("rst_iwait", i_waitrequest, 1);
    chk("rst_dwait", d_waitrequest, 1);
    chk("rst_irdv", i_readdatavalid, 0); chk("rst_drdv", d_readdatavalid, 0);
    chk("rst_irdata", i_readdata, 0);    chk("rst_drdata", d_readdata, 0);
    @(negedge clk); reset = 1'b0;

    // instruction fetch latency
    @(negedge clk);
    i_read = 1'b1; i_address = 32'hBFC00000; waitrequest = 1'b0; readdata = 32'h3C08BFC0;
    #1 chk("f1_read", read, 0); chk("f1_iwait", i_waitrequest, 1);
    @(negedge clk); #1;
    chk("f2_read", read, 1); chk("f2_be", byteenable, 4'hF); chk("f2_addr", address, 32'hBFC00000);
    chk("f2_write", write, 0); chk("f2_iwait", i_waitrequest, 0); chk("f2_dwait", d_waitrequest, 1);
    @(negedge clk); i_read = 1'b0;
    #1 chk("f3_read", read, 0); chk("f3_rdv", i_readdatavalid, 0);
    @(negedge clk); readdata = 32'h0;
    #1 chk("f4_rdv", i_readdatavalid, 1); chk("f4_rdata", i_readdata, 32'h3C08BFC0);
    chk("f4_drdv", d_readdatavalid, 0);
    @(negedge clk);
    #1 chk("f5_rdv", i_readdatavalid, 0); chk("f5_hold", i_readdata, 32'h3C08BFC0);

    // data write stalled three cycles
    @(negedge clk);
    d_write = 1'b1; d_address = 32'h40; d_writedata = 32'hAA11CC22; d_byteenable = 4'b0001;
    waitrequest = 1'b1; n_acc = 0;
    #1 chk("st1_write", write, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("st_write", write, 1); chk("st_addr", address, 32'h40);
      chk("st_wdata", writedata, 32'hAA11CC22); chk("st_be", byteenable, 4'b0001);
      chk("st_dwait", d_waitrequest, 1); chk("st_iwait", i_waitrequest, 1);
      n_acc += int'(write & ~waitrequest);
    end
    @(negedge clk); waitrequest = 1'b0;
    #1 chk("st_go_dwait", d_waitrequest, 0); chk("st_go_iwait", i_waitrequest, 1);
    n_acc += int'(write & ~waitrequest);
    @(negedge clk); d_write = 1'b0;
    #1 chk("st_idle_write", write, 0); n_acc += int'(write & ~waitrequest);
    @(negedge clk); #1 n_acc += int'(write & ~waitrequest);
    chk("st_nacc", n_acc, 1);

    // abort while stalled
    @(negedge clk);
    d_write = 1'b1; d_address = 32'h44; d_writedata = 32'h12345678; d_byteenable = 4'hF;
    waitrequest = 1'b1; n_acc = 0;
    #1 n_acc += int'(write & ~waitrequest);
    @(negedge clk); #1 chk("ab_write_pre", write, 1); n_acc += int'(write & ~waitrequest);
    @(negedge clk); d_write = 1'b0;
    #1 chk("ab_write", write, 0); n_acc += int'(write & ~waitrequest);
    @(negedge clk); waitrequest = 1'b0;
    #1 chk("ab_idle_dwait", d_waitrequest, 1); chk("ab_idle_write", write, 0);
    n_acc += int'(write & ~waitrequest);
    chk("ab_nacc", n_acc, 0);

    // continuous contention from reset: RR alternates, fixed priority always D
    @(negedge clk);
    reset = 1'b1; i_read = 1'b1; d_read = 1'b1; i_address = 32'h100; d_address = 32'h200;
    waitrequest = 1'b0;
    @(negedge clk); reset = 1'b0;
    exp_d = 1'b0; n_gnt = 0; n_fp = 0; rd_pend = 1'b0; rd_val = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      readdata = rd_pend ? rd_val : 32'hDEADBEEF; rd_pend = 1'b0;
      #1;
      chk("ct_rdv_excl", i_readdatavalid & d_readdatavalid, 0);
      if (i_readdatavalid) chk("ct_i_rdata", i_readdata, 32'h100 ^ 32'h5A5A0000);
      if (d_readdatavalid) chk("ct_d_rdata", d_readdata, 32'h200 ^ 32'h5A5A0000);
      chk("fp_iwait", fp_i_waitrequest, 1);
      chk("fp_write", fp_write, 0);
      if (fp_read) begin chk("fp_addr", fp_address, 32'h200); n_fp++; end
      if (read) begin
        chk("ct_grant_d", !d_waitrequest, exp_d);
        chk("ct_grant_i", !i_waitrequest, !exp_d);
        exp_d = !exp_d; n_gnt++;
        rd_pend = 1'b1; rd_val = address ^ 32'h5A5A0000;
      end
    end
    chk("ct_ngrants", 32'(n_gnt >= 12), 1);
    chk("fp_ngrants", 32'(n_fp >= 12), 1);
    @(negedge clk); i_read = 1'b0; d_read = 1'b0;
    repeat (4) @(negedge clk);

    // async reset in GRANT_I
    i_read = 1'b1; i_address = 32'h300; waitrequest = 1'b1;
    @(negedge clk); #1 chk("ar_read_pre", read, 1);
    #2 reset = 1'b1;
    #1 chk("ar_read", read, 0); chk("ar_iwait", i_waitrequest, 1);
    chk("ar_addr", address, 0); chk("ar_be", byteenable, 0); chk("ar_rdv", i_readdatavalid, 0);
    @(negedge clk); reset = 1'b0; i_read = 1'b0; waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1 chk("ar_no_rdv", i_readdatavalid, 0);
    end
    @(negedge clk);
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h300; d_address = 32'h400;
    @(negedge clk); #1 chk("ar_first_addr", address, 32'h300); chk("ar_first_iwait", i_waitrequest, 0);
    @(negedge clk); i_read = 1'b0; d_read = 1'b0;
    repeat (4) @(negedge clk);

    // random traffic against the memory model
    for (int k = 0; k < 16; k++) mem[k] = 32'h10000000 + 32'(k) * 32'h01010101;
    i_busy = 0; d_busy = 0; i_acc = 1'b0; d_acc = 1'b0; rd_pend = 1'b0;
    i_to = 0; d_to = 0; i_exp = '0; d_exp = '0; i_a = '0; d_isrd = 1'b0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clk);
      if (i_acc) begin i_read = 1'b0; i_busy = 2; end
      if (d_acc) begin d_read = 1'b0; d_write = 1'b0; d_busy = d_isrd ? 2 : 0; end
      chk("rd_rdv_excl", i_readdatavalid & d_readdatavalid, 0);
      if (i_readdatavalid) begin
        chk("rd_i_owner", i_busy, 2); chk("rd_i_rdata", i_readdata, i_exp); i_busy = 0;
      end
      if (d_readdatavalid) begin
        chk("rd_d_owner", d_busy, 2); chk("rd_d_rdata", d_readdata, d_exp); d_busy = 0;
      end
      if (cyc < 1500) begin
        if (i_busy == 0 && $urandom_range(2) == 0) begin
          i_a = {26'h2000000, 4'($urandom_range(15)), 2'b00};
          i_address = i_a; i_read = 1'b1; i_busy = 1;
        end
        if (d_busy == 0 && $urandom_range(2) == 0) begin
          d_kind = int'($urandom_range(2));
          d_address = {26'h1000000, 4'($urandom_range(15)), 2'b00};
          d_writedata = $urandom; d_byteenable = 4'($urandom_range(15, 1));
          d_read = (d_kind != 1); d_write = (d_kind != 0); d_isrd = (d_kind == 0); d_busy = 1;
        end
      end
      waitrequest = ($urandom_range(2) == 0);
      readdata = rd_pend ? rd_val : $urandom; rd_pend = 1'b0;
      #1;
      s_acc = (read | write) & ~waitrequest;
      i_acc = i_read & ~i_waitrequest;
      d_acc = (d_read | d_write) & ~d_waitrequest;
      chk("rd_acc_match", s_acc, i_acc | d_acc);
      chk("rd_acc_excl", i_acc & d_acc, 0);
      if (i_acc) begin
        chk("rd_i_addr", address, i_a); chk("rd_i_read", read, 1);
        chk("rd_i_write", write, 0); chk("rd_i_be", byteenable, 4'hF);
        i_exp = mem[i_a[5:2]]; rd_pend = 1'b1; rd_val = mem[address[5:2]];
      end
      if (d_acc) begin
        chk("rd_d_addr", address, d_address); chk("rd_d_write", write, d_write);
        chk("rd_d_read", read, d_isrd);
        if (d_write) begin
          chk("rd_d_wdata", writedata, d_writedata); chk("rd_d_be", byteenable, d_byteenable);
          for (int b = 0; b < 4; b++)
            if (d_byteenable[b]) mem[d_address[5:2]][8*b +: 8] = d_writedata[8*b +: 8];
        end else begin
          d_exp = mem[d_address[5:2]]; rd_pend = 1'b1; rd_val = mem[address[5:2]];
        end
      end
      if (i_busy != 0) i_to++; else i_to = 0;
      if (d_busy != 0) d_to++; else d_to = 0;
      if (i_to > 80) begin chk("rd_i_timeout", i_to, 0); i_busy = 0; i_read = 1'b0; i_to = 0; end
      if (d_to > 80) begin
        chk("rd_d_timeout", d_to, 0); d_busy = 0; d_read = 1'b0; d_write = 1'b0; d_to = 0;
      end
    end
    chk("rd_drain_i", i_busy, 0);
    chk("rd_drain_d", d_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL provide parameter RR_ENABLE, default 1: 1 = round-robin arbitration, 0 = data port has fixed priority.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port reset  in  1  asynchronous active-high reset.
REQ-005 Port i_address  in  32  instruction-master byte address.
REQ-006 Port i_read  in  1  instruction-master read request.
REQ-007 Port i_waitrequest  out  1  instruction-master stall.
REQ-008 Port i_readdata  out  32  instruction-master read data.
REQ-009 Port i_readdatavalid  out  1  i_readdata valid pulse.
REQ-010 Port d_address  in  32  data-master byte address.
REQ-011 Port d_read  in  1  data-master read request.
REQ-012 Port d_write  in  1  data-master write request.
REQ-013 Port d_writedata  in  32  data-master write data.
REQ-014 Port d_byteenable  in  4  data-master byte enables.
REQ-015 Port d_waitrequest  out  1  data-master stall.
REQ-016 Port d_readdata  out  32  data-master read data.
REQ-017 Port d_readdatavalid  out  1  d_readdata valid pulse.
REQ-018 Ports address (out 32), read (out 1), write (out 1), writedata (out 32), byteenable (out 4), waitrequest (in 1), readdata (in 32) SHALL form the shared memory-slave bus.

Function
REQ-019 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D and RESP.
REQ-020 IDLE: all slave outputs 0; both master waitrequests 1; on the next edge go to GRANT_I or GRANT_D if any request is present, else stay in IDLE.
REQ-021 Arbitration, single requester: grant that requester.
REQ-022 Arbitration, both requesting with RR_ENABLE=1: grant the master not recorded in last_grant.
REQ-023 Arbitration, both requesting with RR_ENABLE=0: grant D.
REQ-024 last_grant SHALL update on every grant.
REQ-025 In GRANT_x, the slave address/read/write/writedata/byteenable SHALL be driven combinationally from the granted master.
REQ-026 In GRANT_I, write SHALL be 0 and byteenable SHALL be 4'b1111.
REQ-027 The granted master's waitrequest SHALL equal the slave waitrequest; the other master's waitrequest SHALL be 1.
REQ-028 The grant SHALL be held unchanged while waitrequest=1, with no cycle limit.
REQ-029 A transfer SHALL be accepted at the edge where the block is in GRANT_x, a request is present and waitrequest=0; an accepted write goes to IDLE and an accepted read goes to RESP.
REQ-030 If d_read and d_write are both 1, the write SHALL be issued and read held 0.
REQ-031 If the granted master drops its request before acceptance, no slave transfer SHALL occur and the next state SHALL be IDLE.
REQ-032 RESP lasts one cycle: slave readdata SHALL be captured into the owning master's readdata register and that master's readdatavalid SHALL pulse high for exactly the following cycle; next state IDLE.
REQ-033 i_readdata and d_readdata SHALL hold their last captured value between pulses.
REQ-034 Latency from IDLE with waitrequest=0: write accepted in cycle 2; readdatavalid in cycle 4; minimum 2 cycles per write and 3 cycles per read.
REQ-035 Only one slave transfer SHALL be outstanding; both readdatavalid SHALL never be high together.

Reset
REQ-036 Asserting reset SHALL immediately, without a clock edge, force state IDLE, last_grant=D, read=write=0, address=writedata=0, byteenable=0, i/d_readdatavalid=0, i/d_readdata=0, i/d_waitrequest=1.
REQ-037 A transfer in progress at reset SHALL be abandoned with no readdatavalid pulse.
REQ-038 After reset, the first contested grant SHALL go to I.

Verification
REQ-039 I fetch: i_read=1, i_address=0xBFC00000, waitrequest=0, slave returns 0x3C08BFC0 -> read=1 with byteenable=1111 in cycle 2, i_readdatavalid=1 with i_readdata=0x3C08BFC0 in cycle 4.
REQ-040 Contention with RR_ENABLE=1: i_read and d_read held continuously from reset -> grants I, D, I, D alternate; no readdatavalid overlap.
REQ-041 Stall: D write 0xAA11CC22, byteenable=0001, waitrequest=1 for 3 cycles -> write, address and data stable, d_waitrequest=1 for those 3 cycles, exactly one write accepted, i_waitrequest=1 throughout.
REQ-042 Priority with RR_ENABLE=0: both requesting continuously -> every grant goes to D and i_waitrequest stays 1.
REQ-043 Async reset asserted mid-cycle in GRANT_I -> read=0 and i_waitrequest=1 before the next edge; no i_readdatavalid pulse; after release the first contested grant goes to I.
REQ-044 Abort: D request dropped while waitrequest=1 -> write=0 the same cycle, IDLE next cycle, memory unchanged.
